// File: rtl/ir_key_tracker_if.sv
// ---------------------------------------------------------------------------
// ir_key_tracker_if
//
// Bundles the signals between an IR frame receiver and the key tracker.
//
// Parameters
//    NUM_KEYS     width of the keys_n vector (1..16)
//
// Signals
//    frame_valid  receiver -> tracker   one-cycle strobe, frame_data is a new frame
//    frame_data   receiver -> tracker   32-bit received frame, only [15:0] is used
//    repeat_valid receiver -> tracker   one-cycle strobe, "key still held" code seen
//    keys_n       tracker  -> receiver  active-low one-hot held key, all ones if none
//    key_idx      tracker  -> receiver  index of the current or last pressed key
//    key_press    tracker  -> receiver  one-cycle pulse when a new key goes down
//    key_release  tracker  -> receiver  one-cycle pulse when the held key goes up
//    code_err     tracker  -> receiver  one-cycle pulse on an unrecognised frame
//
// Modports
//    master  the frame source side (drives strobes, observes key state)
//    slave   the tracker side
// ---------------------------------------------------------------------------
interface ir_key_tracker_if #(
   parameter int NUM_KEYS = 16
);

   logic                frame_valid;
   logic [31:0]         frame_data;
   logic                repeat_valid;
   logic [NUM_KEYS-1:0] keys_n;
   logic [3:0]          key_idx;
   logic                key_press;
   logic                key_release;
   logic                code_err;

   modport master (
      output frame_valid,
      output frame_data,
      output repeat_valid,
      input  keys_n,
      input  key_idx,
      input  key_press,
      input  key_release,
      input  code_err
   );

   modport slave (
      input  frame_valid,
      input  frame_data,
      input  repeat_valid,
      output keys_n,
      output key_idx,
      output key_press,
      output key_release,
      output code_err
   );

endinterface

// File: rtl/ir_key_tracker.sv
// ---------------------------------------------------------------------------
// ir_key_tracker
//
// Turns decoded IR remote frames into a "currently held key" indication.
// A recognised frame presses a key; the key stays down while repeat codes
// (or the same frame) keep arriving, and is released HOLD_CYCLES clocks after
// the last refresh. A different recognised key replaces the held one in a
// single cycle, and an unrecognised frame releases whatever is held.
//
// Parameters
//    NUM_KEYS     number of decoded keys (1..16)
//    CODE_PREFIX  required value of frame_data[15:8]
//    HOLD_CYCLES  clocks a key stays asserted after its last refresh (>= 2)
//    CNT_W        hold counter width, 2**CNT_W must exceed HOLD_CYCLES
//
// Ports
//    clk          system clock, everything on the rising edge
//    reset        synchronous, active-high; wins over any same-cycle strobe
//    bus          ir_key_tracker_if slave modport (strobes in, key state out)
//
// All outputs are registered and appear one cycle after the causing strobe.
// ---------------------------------------------------------------------------
module ir_key_tracker #(
   parameter int          NUM_KEYS    = 16,
   parameter logic [7:0]  CODE_PREFIX = 8'h57,
   parameter int          HOLD_CYCLES = 5_000_000,
   parameter int          CNT_W       = 24
) (
   input  logic            clk,
   input  logic            reset,
   ir_key_tracker_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0]    RELOAD  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [NUM_KEYS-1:0] ALL_OFF = '1;

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic [NUM_KEYS-1:0] keys_n_r;
   logic [NUM_KEYS-1:0] keys_n_nxt;
   logic [3:0]          idx_r;
   logic [3:0]          idx_nxt;
   logic                press_r;
   logic                press_nxt;
   logic                release_r;
   logic                release_nxt;
   logic                err_r;
   logic                err_nxt;

   logic                lut_hit;
   logic [3:0]          lut_idx;
   logic                frame_known;
   logic [NUM_KEYS-1:0] lut_keys_n;

   // The upper half of the frame carries the inverted command and address
   // copies, which the receiver has already validated; they are not needed.
   logic unused_frame_hi;
   assign unused_frame_hi = ^bus.frame_data[31:16];

   // Command byte lookup. Every valid command ends in nibble F; the upper
   // nibble encodes the key. Anything outside the table is an unknown code.
   always_comb begin
      lut_hit = 1'b1;
      lut_idx = 4'd0;
      case (bus.frame_data[7:0])
         8'h2F:   lut_idx = 4'd0;
         8'h7F:   lut_idx = 4'd1;
         8'hBF:   lut_idx = 4'd2;
         8'h3F:   lut_idx = 4'd3;
         8'hDF:   lut_idx = 4'd4;
         8'h5F:   lut_idx = 4'd5;
         8'h9F:   lut_idx = 4'd6;
         8'h1F:   lut_idx = 4'd7;
         8'hEF:   lut_idx = 4'd8;
         8'h6F:   lut_idx = 4'd9;
         8'h0F:   lut_idx = 4'd10;
         8'hAF:   lut_idx = 4'd11;
         8'hCF:   lut_idx = 4'd12;
         8'h4F:   lut_idx = 4'd13;
         8'h8F:   lut_idx = 4'd14;
         8'hFF:   lut_idx = 4'd15;
         default: lut_hit = 1'b0;
      endcase
   end

   // A frame only counts as a key when the prefix matches, the command is in
   // the table and the decoded index exists in this build (smaller NUM_KEYS
   // builds treat the upper table entries as unknown codes).
   always_comb begin
      frame_known = (bus.frame_data[15:8] == CODE_PREFIX) && lut_hit
                    && (int'(lut_idx) < NUM_KEYS);
      lut_keys_n  = ~(NUM_KEYS'(1) << lut_idx);
   end

   // Next-state and next-output logic. Refreshes (repeat code or the same
   // key again) reload the hold counter and take priority over the expiry
   // check, so a refresh landing exactly on counter==0 never releases.
   // frame_valid is examined before repeat_valid, so a repeat strobe in the
   // same cycle as a frame is simply dropped.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      keys_n_nxt  = keys_n_r;
      idx_nxt     = idx_r;
      press_nxt   = 1'b0;
      release_nxt = 1'b0;
      err_nxt     = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.frame_valid) begin
               if (frame_known) begin
                  state_nxt  = HELD;
                  idx_nxt    = lut_idx;
                  keys_n_nxt = lut_keys_n;
                  press_nxt  = 1'b1;
                  cnt_nxt    = RELOAD;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end

         HELD: begin
            if (bus.frame_valid) begin
               if (frame_known) begin
                  cnt_nxt = RELOAD;
                  if (lut_idx != idx_r) begin
                     idx_nxt     = lut_idx;
                     keys_n_nxt  = lut_keys_n;
                     press_nxt   = 1'b1;
                     release_nxt = 1'b1;
                  end
               end else begin
                  state_nxt   = IDLE;
                  keys_n_nxt  = ALL_OFF;
                  release_nxt = 1'b1;
                  err_nxt     = 1'b1;
                  cnt_nxt     = '0;
               end
            end else if (bus.repeat_valid) begin
               cnt_nxt = RELOAD;
            end else if (cnt == '0) begin
               state_nxt   = IDLE;
               keys_n_nxt  = ALL_OFF;
               release_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end

         default: begin
            state_nxt  = IDLE;
            keys_n_nxt = ALL_OFF;
         end
      endcase
   end

   // State and output registers. Reset drops a held key silently: no release
   // pulse is produced, the key simply disappears from keys_n.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         keys_n_r  <= ALL_OFF;
         idx_r     <= 4'd0;
         press_r   <= 1'b0;
         release_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         keys_n_r  <= keys_n_nxt;
         idx_r     <= idx_nxt;
         press_r   <= press_nxt;
         release_r <= release_nxt;
         err_r     <= err_nxt;
      end
   end

   assign bus.keys_n      = keys_n_r;
   assign bus.key_idx     = idx_r;
   assign bus.key_press   = press_r;
   assign bus.key_release = release_r;
   assign bus.code_err    = err_r;

endmodule

// File: tb/tb_ir_key_tracker.sv
// ---------------------------------------------------------------------------
// tb_ir_key_tracker
//
// Drives two tracker builds (16 keys and 10 keys, both with an 8-cycle hold)
// with directed frames and repeat codes. Every expected pulse event is
// queued with the cycle it must appear in; monitors pop and compare each
// pulse the trackers produce. Level checks of keys_n/key_idx are done
// directly at chosen points.
// ---------------------------------------------------------------------------
module tb_ir_key_tracker;

   typedef struct {
      int unsigned ev_cyc;
      logic [15:0] keys;
      logic [3:0]  idx;
      logic        press;
      logic        rel;
      logic        err;
   } exp_t;

   logic        clk;
   logic        reset;
   int unsigned cyc;
   int          total;
   int          bad;
   exp_t        sb16[$];
   exp_t        sb10[$];
   exp_t        m16;
   exp_t        m10;
   int unsigned e;

   ir_key_tracker_if #(.NUM_KEYS(16)) bus16 ();
   ir_key_tracker_if #(.NUM_KEYS(10)) bus10 ();

   ir_key_tracker #(
      .NUM_KEYS(16), .CODE_PREFIX(8'h57), .HOLD_CYCLES(8), .CNT_W(4)
   ) dut16 (
      .clk(clk), .reset(reset), .bus(bus16)
   );

   ir_key_tracker #(
      .NUM_KEYS(10), .CODE_PREFIX(8'h57), .HOLD_CYCLES(8), .CNT_W(4)
   ) dut10 (
      .clk(clk), .reset(reset), .bus(bus10)
   );

   // Free-running 100 MHz style clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Rising-edge counter; an event caused by a strobe sampled at edge N is
   // tagged with cyc == N when the monitor sees it on the following negedge.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor for the 16-key build: keys_n must never show two keys, and
   // every pulse must match the next queued expectation, cycle included.
   always @(negedge clk) begin
      total++;
      if ($countones(~bus16.keys_n) > 1) begin
         bad++;
         $display("[TB] FAIL onehot16 cyc=%0d keys_n=%h required at most one low bit", cyc, bus16.keys_n);
      end
      if (bus16.key_press === 1'b1 || bus16.key_release === 1'b1 || bus16.code_err === 1'b1) begin
         total++;
         if (sb16.size() == 0) begin
            bad++;
            $display("[TB] FAIL event16 cyc=%0d unexpected pulse p=%b r=%b e=%b keys_n=%h", cyc, bus16.key_press, bus16.key_release, bus16.code_err, bus16.keys_n);
         end else begin
            m16 = sb16.pop_front();
            if (cyc != m16.ev_cyc || bus16.keys_n !== m16.keys || bus16.key_idx !== m16.idx ||
                bus16.key_press !== m16.press || bus16.key_release !== m16.rel || bus16.code_err !== m16.err) begin
               bad++;
               $display("[TB] FAIL event16 got cyc=%0d keys_n=%h idx=%0d p=%b r=%b e=%b, required cyc=%0d keys_n=%h idx=%0d p=%b r=%b e=%b",
                        cyc, bus16.keys_n, bus16.key_idx, bus16.key_press, bus16.key_release, bus16.code_err,
                        m16.ev_cyc, m16.keys, m16.idx, m16.press, m16.rel, m16.err);
            end
         end
      end
   end

   // Same scoreboard check for the 10-key build.
   always @(negedge clk) begin
      if (bus10.key_press === 1'b1 || bus10.key_release === 1'b1 || bus10.code_err === 1'b1) begin
         total++;
         if (sb10.size() == 0) begin
            bad++;
            $display("[TB] FAIL event10 cyc=%0d unexpected pulse p=%b r=%b e=%b keys_n=%h", cyc, bus10.key_press, bus10.key_release, bus10.code_err, bus10.keys_n);
         end else begin
            m10 = sb10.pop_front();
            if (cyc != m10.ev_cyc || {6'b0, bus10.keys_n} !== m10.keys || bus10.key_idx !== m10.idx ||
                bus10.key_press !== m10.press || bus10.key_release !== m10.rel || bus10.code_err !== m10.err) begin
               bad++;
               $display("[TB] FAIL event10 got cyc=%0d keys_n=%h idx=%0d p=%b r=%b e=%b, required cyc=%0d keys_n=%h idx=%0d p=%b r=%b e=%b",
                        cyc, bus10.keys_n, bus10.key_idx, bus10.key_press, bus10.key_release, bus10.code_err,
                        m10.ev_cyc, m10.keys, m10.idx, m10.press, m10.rel, m10.err);
            end
         end
      end
   end

   task automatic push16(input int unsigned c, input logic [15:0] k, input logic [3:0] i,
                         input logic p, input logic r, input logic er);
      exp_t x;
      x.ev_cyc = c; x.keys = k; x.idx = i; x.press = p; x.rel = r; x.err = er;
      sb16.push_back(x);
   endtask

   task automatic push10(input int unsigned c, input logic [15:0] k, input logic [3:0] i,
                         input logic p, input logic r, input logic er);
      exp_t x;
      x.ev_cyc = c; x.keys = k; x.idx = i; x.press = p; x.rel = r; x.err = er;
      sb10.push_back(x);
   endtask

   // Drives one strobe cycle starting at a negedge; returns on the next one.
   task automatic applyStimulus(input bit to10, input logic fv, input logic [31:0] data, input logic rv);
      if (to10) begin
         bus10.frame_valid = fv; bus10.frame_data = data; bus10.repeat_valid = rv;
      end else begin
         bus16.frame_valid = fv; bus16.frame_data = data; bus16.repeat_valid = rv;
      end
      @(negedge clk);
      bus16.frame_valid = 1'b0; bus16.repeat_valid = 1'b0;
      bus10.frame_valid = 1'b0; bus10.repeat_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Level check of the 16-key build's outputs; pulses given as {press,release,err}.
   task automatic checkOutput(input string name, input logic [15:0] k, input logic [3:0] i, input logic [2:0] pulses);
      total++;
      if (bus16.keys_n !== k || bus16.key_idx !== i ||
          {bus16.key_press, bus16.key_release, bus16.code_err} !== pulses) begin
         bad++;
         $display("[TB] FAIL %s got keys_n=%h idx=%0d pulses=%b, required keys_n=%h idx=%0d pulses=%b",
                  name, bus16.keys_n, bus16.key_idx, {bus16.key_press, bus16.key_release, bus16.code_err}, k, i, pulses);
      end
   endtask

   // Directed scenario sequence.
   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus16.frame_valid = 1'b0; bus16.frame_data = 32'h0; bus16.repeat_valid = 1'b0;
      bus10.frame_valid = 1'b0; bus10.frame_data = 32'h0; bus10.repeat_valid = 1'b0;
      idle(3);
      checkOutput("reset_state", 16'hFFFF, 4'd0, 3'b000);
      reset = 1'b0;
      idle(2);

      // Press key 2, let it time out 8 cycles later.
      $display("[TB] press and timeout");
      e = cyc + 1;
      push16(e, 16'hFFFB, 4'd2, 1'b1, 1'b0, 1'b0);
      push16(e + 8, 16'hFFFF, 4'd2, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 32'h0000_57BF, 1'b0);
      checkOutput("press_key2", 16'hFFFB, 4'd2, 3'b100);
      idle(12);

      // Press key 0 and keep it alive with four repeats, 6 cycles apart.
      $display("[TB] repeats");
      e = cyc + 1;
      push16(e, 16'hFFFE, 4'd0, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 32'h0000_572F, 1'b0);
      idle(5);
      for (int i = 0; i < 4; i++) begin
         e = cyc + 1;
         applyStimulus(0, 1'b0, 32'h0, 1'b1);
         checkOutput("repeat_hold", 16'hFFFE, 4'd0, 3'b000);
         idle(5);
      end
      push16(e + 8, 16'hFFFF, 4'd0, 1'b0, 1'b1, 1'b0);
      idle(6);

      // Key 1 held, then key 15 replaces it in one cycle.
      $display("[TB] key switch");
      e = cyc + 1;
      push16(e, 16'hFFFD, 4'd1, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 32'h0000_577F, 1'b0);
      idle(2);
      e = cyc + 1;
      push16(e, 16'h7FFF, 4'd15, 1'b1, 1'b1, 1'b0);
      push16(e + 8, 16'hFFFF, 4'd15, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 1'b1, 32'h0000_57FF, 1'b0);
      idle(10);

      // Unknown codes in IDLE and while HELD.
      $display("[TB] unknown codes");
      e = cyc + 1;
      push16(e, 16'hFFFF, 4'd15, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 32'h0000_5612, 1'b0);
      idle(1);
      e = cyc + 1;
      push16(e, 16'hFFFF, 4'd15, 1'b0, 1'b0, 1'b1);
      applyStimulus(0, 1'b1, 32'h0000_5712, 1'b0);
      idle(1);
      e = cyc + 1;
      push16(e, 16'hFFDF, 4'd5, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 32'h0000_575F, 1'b0);
      idle(2);
      e = cyc + 1;
      push16(e, 16'hFFFF, 4'd5, 1'b0, 1'b1, 1'b1);
      applyStimulus(0, 1'b1, 32'h0000_5612, 1'b0);
      checkOutput("unknown_held", 16'hFFFF, 4'd5, 3'b011);
      idle(3);

      // Frame and repeat together, then a refresh exactly at counter==0.
      $display("[TB] simultaneous strobes and last-cycle refresh");
      e = cyc + 1;
      push16(e, 16'hFFBF, 4'd6, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 32'h0000_579F, 1'b1);
      idle(7);
      push16(e + 16, 16'hFFFF, 4'd6, 1'b0, 1'b1, 1'b0);
      applyStimulus(0, 1'b0, 32'h0, 1'b1);
      checkOutput("refresh_at_zero", 16'hFFBF, 4'd6, 3'b000);
      idle(10);
      applyStimulus(0, 1'b0, 32'h0, 1'b1);
      checkOutput("idle_repeat", 16'hFFFF, 4'd6, 3'b000);
      idle(2);

      // Reset wins over a same-cycle frame while a key is held.
      $display("[TB] reset while held");
      e = cyc + 1;
      push16(e, 16'hFFEF, 4'd4, 1'b1, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 32'h0000_57DF, 1'b0);
      idle(2);
      reset = 1'b1;
      bus16.frame_valid = 1'b1;
      bus16.frame_data  = 32'h0000_57DF;
      @(negedge clk);
      reset = 1'b0;
      bus16.frame_valid = 1'b0;
      checkOutput("reset_over_frame", 16'hFFFF, 4'd0, 3'b000);
      idle(12);

      // 10-key build: index 10 is unknown, index 9 is the top key.
      $display("[TB] ten-key build");
      e = cyc + 1;
      push10(e, 16'h03FF, 4'd0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1, 1'b1, 32'h0000_570F, 1'b0);
      idle(2);
      e = cyc + 1;
      push10(e, 16'h01FF, 4'd9, 1'b1, 1'b0, 1'b0);
      push10(e + 8, 16'h03FF, 4'd9, 1'b0, 1'b1, 1'b0);
      applyStimulus(1, 1'b1, 32'h0000_576F, 1'b0);
      idle(12);

      // Any expectation left over is a pulse that never arrived.
      total++;
      if (sb16.size() != 0) begin
         bad++;
         $display("[TB] FAIL missing16 got %0d pending events, required 0 (next cyc=%0d)", sb16.size(), sb16[0].ev_cyc);
      end
      total++;
      if (sb10.size() != 0) begin
         bad++;
         $display("[TB] FAIL missing10 got %0d pending events, required 0 (next cyc=%0d)", sb10.size(), sb10[0].ev_cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ir_key_tracker.md
IR_KEY_TRACKER -- requirements
Module: ir_key_tracker

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 16, number of decoded keys (1..16).
REQ-002 SHALL have parameter CODE_PREFIX, default 8'h57, required value of frame_data[15:8].
REQ-003 SHALL have parameter HOLD_CYCLES, default 5_000_000, clocks a key stays asserted after its last refresh (>=2).
REQ-004 SHALL have parameter CNT_W, default 24, hold-counter width (2**CNT_W > HOLD_CYCLES).
REQ-005 SHALL have one clock and a synchronous active-high reset: clk  in  1  system clock, all logic on rising edge.
REQ-006 SHALL have: reset  in  1  synchronous, active-high.
REQ-007 SHALL have: frame_valid  in  1  one-cycle strobe, frame_data holds a new full frame.
REQ-008 SHALL have: frame_data  in  32  received frame; bits [31:16] ignored.
REQ-009 SHALL have: repeat_valid  in  1  one-cycle strobe, repeat (key-still-held) code received.
REQ-010 SHALL have: keys_n  out  NUM_KEYS  active-low one-hot held key, all ones when none.
REQ-011 SHALL have: key_idx  out  4  index of current/last pressed key.
REQ-012 SHALL have: key_press  out  1  one-cycle pulse on new key.
REQ-013 SHALL have: key_release  out  1  one-cycle pulse on key release.
REQ-014 SHALL have: code_err  out  1  one-cycle pulse on unrecognised frame.

Function
REQ-015 SHALL decode frame_data[7:0] when frame_data[15:8]==CODE_PREFIX: 2F->0, 7F->1, BF->2, 3F->3, DF->4, 5F->5, 9F->6, 1F->7, EF->8, 6F->9, 0F->10, AF->11, CF->12, 4F->13, 8F->14, FF->15.
REQ-016 SHALL treat a frame as unknown if prefix mismatches, low byte is not in the table, or decoded index >= NUM_KEYS.
REQ-017 SHALL implement states IDLE and HELD; all outputs registered, visible one cycle after the causing strobe.
REQ-018 IDLE + known frame: -> HELD, key_idx=index, keys_n[index]=0, key_press=1, counter=HOLD_CYCLES-1.
REQ-019 IDLE + unknown frame: code_err=1, stay IDLE, keys_n and key_idx unchanged.
REQ-020 IDLE + repeat_valid: ignored, no output change.
REQ-021 HELD, no strobe: counter decrements by 1 per clock; at counter==0 -> IDLE, keys_n all ones, key_release=1.
REQ-022 HELD + repeat_valid or known frame with same index: counter reloads HOLD_CYCLES-1, no pulses.
REQ-023 HELD + known frame with different index: stay HELD, key_idx and keys_n switch to new key, key_release=1 and key_press=1 same cycle, counter reloads.
REQ-024 HELD + unknown frame: code_err=1, key_release=1, -> IDLE, keys_n all ones.
REQ-025 frame_valid and repeat_valid in the same cycle: frame_valid processed, repeat_valid discarded.
REQ-026 Refresh in the cycle counter==0: refresh wins, no release.
REQ-027 keys_n SHALL never have more than one bit low; key_press/key_release/code_err never high two consecutive cycles without a causing strobe.

Reset
REQ-028 reset high at a clock edge SHALL force IDLE, keys_n all ones, key_idx=0, key_press=0, key_release=0, code_err=0, counter=0, overriding any same-cycle strobe.
REQ-029 reset while HELD SHALL release the key without a key_release pulse.

Verification (NUM_KEYS=16, HOLD_CYCLES=8)
REQ-030 frame 0x0000_57BF in IDLE -> next cycle keys_n=16'hFFFB, key_idx=2, key_press pulse; no refresh -> release exactly 8 cycles after press, keys_n=16'hFFFF, key_release pulse.
REQ-031 Press 0x572F then repeat_valid every 6 cycles for 4 repeats -> keys_n stays 16'hFFFE throughout, release 8 cycles after last repeat.
REQ-032 Held key 1 (0x577F), then frame 0x57FF -> keys_n=16'h7FFF, key_idx=15, key_press and key_release both pulse same cycle.
REQ-033 frame 0x5612 in IDLE -> code_err pulse only; same frame while HELD -> code_err + key_release, keys_n=16'hFFFF.
REQ-034 NUM_KEYS=10 build: frame 0x570F -> code_err, no press; frame 0x576F -> keys_n=10'h1FF, key_idx=9.
REQ-035 reset asserted in same cycle as frame 0x57DF while HELD -> next cycle IDLE, keys_n all ones, key_idx=0, no pulses.
